ula_seq: RTL
============

Name: ula_seq

Overview:
Parametrised, sequential successor to the 16-bit combinational ULA. It takes operands A/B with an opcode through a valid/ready handshake and returns a registered result with status flags. MUL executes as an iterative shift-add over several cycles. It sits between a controller/testbench driver and the Basys3 top level, which instantiates it in place of the combinational ULA core.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept an operation this cycle
A  in  WIDTH  operand A
B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount for SHL/SHR
op  in  3  opcode (see package)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
C  out  WIDTH  result
flags  out  4  {N,V,CY,Z}

Behaviour:
- Reset (async assert, sync deassert at clk edge): state=IDLE, out_valid=0, C=0, flags=0, multiplier counter=0. in_ready=1 once out of reset.
- Transfer in occurs on in_valid&&in_ready; transfer out on out_valid&&out_ready.
- Opcodes: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 SHL A<<B[SHW-1:0]; 6 SHR logical A>>B[SHW-1:0]; 7 MUL, low WIDTH bits of A*B (unsigned).
- Flags: Z=(C==0); N=C[WIDTH-1]; ADD CY=carry-out; SUB CY=carry-out of A+~B+1 (1 when A>=B unsigned); ADD/SUB V=signed overflow; MUL CY=1 if upper WIDTH product bits nonzero; V=0 and CY=0 for all other ops.
- FSM states IDLE, MUL, DONE.
  IDLE: in_ready=1. On accept: op!=7 -> compute, register C/flags, go DONE; op==7 -> latch A,B, clear accumulator/counter, go MUL.
  MUL: in_ready=0; one multiplier bit per cycle, WIDTH cycles; after the last bit register C/flags, go DONE.
  DONE: out_valid=1, C/flags stable. in_ready=out_ready. On out_ready with no new accept -> IDLE. On out_ready with an accept -> handle as IDLE accept in the same edge (back-to-back).
- Latency: accept at edge T -> out_valid at T+1 (ALU ops), T+WIDTH+1 (MUL). Throughput of 1 op/cycle for non-MUL ops with out_ready held high.
- Backpressure: C/flags/out_valid are held unchanged while out_valid&&!out_ready; in_ready stays 0.
- Inputs are ignored (no latch) when in_ready=0, including in_valid during MUL.
- Shift amounts >= WIDTH cannot occur because only SHW bits are used; SHL/SHR by 0 returns A.
- Reset mid-MUL or in DONE: result is discarded, outputs return to reset values immediately.

Decomposition:
- Package ula_pkg: opcode localparams (OP_ADD..OP_MUL), flag bit indices (FLG_Z=0, FLG_CY=1, FLG_V=2, FLG_N=3), FSM state encoding.
- Sub-module ula_mul_iter: shift-add multiplier with start/busy/done, parameter WIDTH, producing a 2*WIDTH product. The ALU ops and the FSM stay in ula_seq.

Test Plan:
1. ADD A=0xFFFF,B=0x0001 -> next cycle out_valid, C=0x0000, flags Z=1,CY=1,V=0,N=0.
2. SUB A=0x8000,B=0x0001 -> C=0x7FFF, V=1, CY=1, N=0. SUB A=0x0001,B=0x0002 -> C=0xFFFF, CY=0, N=1.
3. MUL A=0x0123,B=0x0010 -> out_valid 17 cycles after accept, C=0x1230, CY=0, in_ready=0 throughout. MUL 0x1000*0x0100 -> C=0x0000, Z=1, CY=1.
4. Backpressure: XOR 0x00FF^0x0F0F, out_ready low for 5 cycles -> C=0x0FF0 held, in_ready=0. Release -> one transfer, then IDLE.
5. Back-to-back with out_ready=1: issue AND, OR, SHL(A=0x0001,B=0x000F) on consecutive cycles -> three results on consecutive cycles, last C=0x8000, N=1.
6. Assert rst 5 cycles into a MUL -> out_valid=0, C=0 asynchronously. After release in_ready=1, and the next ADD 2+3 gives C=0x0005.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ULA: opcodes, flag bit positions and FSM states.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // flags output is packed as {N, V, CY, Z}
  localparam int FLG_Z  = 0;
  localparam int FLG_CY = 1;
  localparam int FLG_V  = 2;
  localparam int FLG_N  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ula_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// done and product are combinational so the caller can register the result on the last-bit edge.
module ula_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [SHW-1:0]     count;

  always_comb begin
    acc_next = acc + (b_sh[0] ? a_sh : '0);
    done     = busy && (count == LAST);
    product  = acc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      a_sh  <= {{WIDTH{1'b0}}, a};
      b_sh  <= b;
      acc   <= '0;
      count <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc   <= acc_next;
      a_sh  <= a_sh << 1;
      b_sh  <= b_sh >> 1;
      count <= done ? '0 : count + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Sequential ULA with valid/ready handshakes: single-cycle ALU ops, iterative MUL,
// registered result and {N,V,CY,Z} flags held until the consumer takes them.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  state_t state, state_next;

  logic                 accept;
  logic                 is_mul;
  logic                 mul_start;
  logic                 mul_busy;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;

  logic [WIDTH:0]       add_ext;
  logic [WIDTH:0]       sub_ext;
  logic [SHW-1:0]       sh_amt;
  logic [WIDTH-1:0]     alu_c;
  logic                 alu_cy;
  logic                 alu_v;
  logic [3:0]           alu_flags;
  logic [WIDTH-1:0]     mul_c;
  logic [3:0]           mul_flags;

  assign is_mul    = (op == OP_MUL);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;

  ula_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // SUB uses A + ~B + 1 so that CY reads as "no borrow" (A >= B unsigned)
  always_comb begin
    add_ext = {1'b0, A} + {1'b0, B};
    sub_ext = {1'b0, A} + {1'b0, ~B} + (WIDTH + 1)'(1);
    sh_amt  = B[SHW-1:0];
    alu_c   = '0;
    alu_cy  = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_c  = add_ext[WIDTH-1:0];
        alu_cy = add_ext[WIDTH];
        alu_v  = (A[WIDTH-1] == B[WIDTH-1]) && (add_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_c  = sub_ext[WIDTH-1:0];
        alu_cy = sub_ext[WIDTH];
        alu_v  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_c = A & B;
      OP_OR:   alu_c = A | B;
      OP_XOR:  alu_c = A ^ B;
      OP_SHL:  alu_c = A << sh_amt;
      OP_SHR:  alu_c = A >> sh_amt;
      default: alu_c = '0;
    endcase

    alu_flags         = '0;
    alu_flags[FLG_Z]  = (alu_c == '0);
    alu_flags[FLG_N]  = alu_c[WIDTH-1];
    alu_flags[FLG_CY] = alu_cy;
    alu_flags[FLG_V]  = alu_v;

    mul_c             = mul_product[WIDTH-1:0];
    mul_flags         = '0;
    mul_flags[FLG_Z]  = (mul_c == '0);
    mul_flags[FLG_N]  = mul_c[WIDTH-1];
    mul_flags[FLG_CY] = |mul_product[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A DONE state with out_ready behaves exactly like IDLE for a new accept
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = is_mul ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_next = ST_DONE;
        end else if (!mul_busy) begin
          state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (accept) begin
            state_next = is_mul ? ST_MUL : ST_DONE;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C     <= '0;
      flags <= '0;
    end else if (mul_done) begin
      C     <= mul_c;
      flags <= mul_flags;
    end else if (accept && !is_mul) begin
      C     <= alu_c;
      flags <= alu_flags;
    end
  end

endmodule
